// File: rtl/lpm_fifo_wr_arbiter.sv
// lpm_fifo_wr_arbiter
// Round-robin arbiter that shares the write port of one single-clock LPM FIFO
// among num_req producers. Writes are throttled from usedw_in/fifo_full so the
// FIFO never overflows.
// Optional feature macro: LPM_FIFO_ARB_BURST_EN
//   defined   : a grant covers a burst of up to max_burst words
//   undefined : every accepted word ends the grant (word-level round-robin)
module lpm_fifo_wr_arbiter #(
  parameter int lpm_width    = 32,
  parameter int lpm_widthad  = 4,
  parameter int lpm_numwords = 16,
  parameter int num_req      = 4,
  parameter int max_burst    = 4
) (
  input  logic                         clock,
  input  logic                         sclr,
  input  logic [num_req-1:0]           req,
  input  logic [num_req*lpm_width-1:0] data_in,
  output logic [num_req-1:0]           ack,
  output logic [num_req-1:0]           grant,
  input  logic [lpm_widthad-1:0]       usedw_in,
  input  logic                         fifo_full,
  output logic                         wrreq,
  output logic [lpm_width-1:0]         data
);

  localparam int PTR_W = (num_req > 1) ? $clog2(num_req) : 1;

`ifdef LPM_FIFO_ARB_BURST_EN
  localparam int EFF_BURST = max_burst;
`else
  localparam int EFF_BURST = 1;
`endif

  localparam int CNT_W = (EFF_BURST > 1) ? $clog2(EFF_BURST) : 1;

  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(EFF_BURST - 1);
  localparam logic [PTR_W-1:0]       LAST_REQ = PTR_W'(num_req - 1);
  localparam logic [lpm_widthad:0]   DEPTH    = (lpm_widthad + 1)'(lpm_numwords);
  localparam logic [num_req-1:0]     ONE      = num_req'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]           state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     owner;
  logic [CNT_W-1:0]     cnt;

  logic [lpm_widthad:0] used_sum;
  logic                 space;
  logic                 owner_req;
  logic                 accept;
  logic                 burst_end;
  logic [PTR_W-1:0]     next_ptr;
  logic [lpm_width-1:0] sel_word;

  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     cand;
  int                   cand_int;

  // The word already registered in wrreq is not yet visible in usedw_in, so it
  // is counted here; FIFO reads are ignored, which can only under-estimate room.
  always_comb begin
    used_sum = {1'b0, usedw_in} + {{lpm_widthad{1'b0}}, wrreq};
    space    = !fifo_full && (used_sum < DEPTH);
  end

  // Round-robin search: first requesting index at or above ptr, wrapping round.
  // Walking the offsets downward lets the smallest offset win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    cand_int   = 0;
    for (int k = num_req - 1; k >= 0; k--) begin
      cand_int = int'(ptr) + k;
      if (cand_int >= num_req) begin
        cand_int = cand_int - num_req;
      end
      cand = PTR_W'(cand_int);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Burst-owner handshake: only the owner can be acknowledged, never during
  // reset, and only while the FIFO provably has room for the word.
  always_comb begin
    owner_req = req[owner];
    accept    = (state == BURST) && !sclr && owner_req && space;
    ack       = accept ? (ONE << owner) : '0;
    burst_end = !owner_req || (accept && (cnt == LAST_CNT));
    next_ptr  = (owner == LAST_REQ) ? '0 : owner + 1'b1;
    sel_word  = data_in[owner*lpm_width +: lpm_width];
  end

  // Arbitration state, burst bookkeeping and the registered FIFO write port.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      wrreq <= 1'b0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wrreq <= 1'b0;
          if (pick_valid) begin
            grant <= ONE << pick_idx;
            owner <= pick_idx;
            cnt   <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            wrreq <= 1'b1;
            data  <= sel_word;
            cnt   <= cnt + 1'b1;
          end else begin
            wrreq <= 1'b0;
          end
          if (burst_end) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= next_ptr;
          end
        end
        default: begin
          state <= IDLE;
          wrreq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpm_fifo_wr_arbiter.sv
// tb_lpm_fifo_wr_arbiter
// Directed bench for lpm_fifo_wr_arbiter: producer model, behavioural FIFO
// model, a vector table of per-cycle expectations and hand-written corner cases.
// Expectations follow LPM_FIFO_ARB_BURST_EN exactly as the design does.
module tb_lpm_fifo_wr_arbiter;

  localparam int W     = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NR    = 4;
  localparam int MB    = 4;

`ifdef LPM_FIFO_ARB_BURST_EN
  localparam int EB = MB;
`else
  localparam int EB = 1;
`endif

  logic            clock = 1'b0;
  logic            sclr;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] data_in;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   grant;
  logic [AW-1:0]   usedw_in;
  logic            fifo_full;
  logic            wrreq;
  logic [W-1:0]    data;

  // Free-running clock, period 10
  always #5 clock = ~clock;

  lpm_fifo_wr_arbiter #(
    .lpm_width(W), .lpm_widthad(AW), .lpm_numwords(DEPTH),
    .num_req(NR), .max_burst(MB)
  ) dut (
    .clock(clock), .sclr(sclr), .req(req), .data_in(data_in),
    .ack(ack), .grant(grant), .usedw_in(usedw_in), .fifo_full(fifo_full),
    .wrreq(wrreq), .data(data)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] wordOf(input int r, input int s);
    return 32'hA000_0000 | (32'(r) << 16) | (32'(s) & 32'h0000_FFFF);
  endfunction

  // Producers: each requester presents its next word until it is acknowledged
  int seqDut [NR] = '{default: 0};
  always_comb begin
    data_in = '0;
    for (int i = 0; i < NR; i++) data_in[i*W +: W] = wordOf(i, seqDut[i]);
  end
  always @(posedge clock) begin
    for (int i = 0; i < NR; i++) if (ack[i]) seqDut[i] <= seqDut[i] + 1;
  end

  // FIFO occupancy model: captures wrreq each edge, optional read, flushable
  int   fifoCount = 0;
  logic rd = 1'b0;
  logic fflush = 1'b0;
  always @(posedge clock) begin
    if (fflush) fifoCount <= 0;
    else fifoCount <= fifoCount + (wrreq ? 1 : 0) - ((rd && fifoCount > 0) ? 1 : 0);
  end
  assign usedw_in  = AW'(fifoCount);
  assign fifo_full = (fifoCount >= DEPTH);

  typedef struct {
    logic          sclr;
    logic [NR-1:0] req;
    logic          rd;
    logic [NR-1:0] expAck;
    logic [NR-1:0] expGrant;
    logic          expWrreq;
  } vec_t;

  vec_t          vecs [$];
  logic [W-1:0]  expq [$];
  int            expSeq [NR] = '{default: 0};
  int            rem [NR];
  int            mptr = 0;
  logic          drainOn = 1'b0;
  logic [NR-1:0] lastAck = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sclr = v.sclr;
    req  = v.req;
    rd   = v.rd;
  endtask

  function automatic logic [NR-1:0] reqBits();
    logic [NR-1:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[i] = (rem[i] > 0);
    return r;
  endfunction

  task automatic addVec(input logic s, input logic [NR-1:0] a, input logic [NR-1:0] g);
    vec_t v;
    v.sclr     = s;
    v.req      = reqBits();
    v.rd       = drainOn;
    v.expAck   = a;
    v.expGrant = g;
    v.expWrreq = |lastAck;
    vecs.push_back(v);
    lastAck = s ? '0 : a;
  endtask

  task automatic addReset();
    addVec(1'b1, '0, '0);
    mptr = 0;
  endtask

  // Expected cycles for the words in rem[]: one IDLE cycle per grant, up to EB
  // accepted words, and an extra granted cycle when the owner drops req early.
  task automatic genRun();
    int g, b;
    logic [NR-1:0] oh;
    while (|reqBits()) begin
      g = 0;
      for (int k = NR - 1; k >= 0; k--) if (rem[(mptr + k) % NR] > 0) g = (mptr + k) % NR;
      oh = NR'(1) << g;
      addVec(1'b0, '0, '0);
      b = 0;
      while (b < EB && rem[g] > 0) begin
        addVec(1'b0, oh, oh);
        rem[g]--;
        b++;
      end
      if (b < EB) addVec(1'b0, '0, oh);
      mptr = (g + 1) % NR;
    end
    addVec(1'b0, '0, '0);
  endtask

  task automatic pushExpected(input logic [NR-1:0] a);
    for (int r = 0; r < NR; r++) begin
      if (a[r]) begin
        expq.push_back(wordOf(r, expSeq[r]));
        expSeq[r]++;
      end
    end
  endtask

  // A registered write is being presented this cycle: it must fit and match.
  task automatic writeCheck();
    if (wrreq === 1'b1) begin
      checkOutput("write_room", 32'(fifoCount < DEPTH), 32'd1);
      if (expq.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
      else checkOutput("wdata", data, expq.pop_front());
    end
  endtask

  initial begin
    int kc, nAck, nWr, viol;

    // Test 1: one requester, six words
    rem = '{6, 0, 0, 0};
    genRun();
    // Test 2: all four requesters, sixteen words each, FIFO drained every cycle
    addReset();
    drainOn = 1'b1;
    rem = '{16, 16, 16, 16};
    genRun();
    drainOn = 1'b0;
    // Test 5: two sparse requesters alternate
    addReset();
    rem = '{4, 0, 4, 0};
    genRun();
    // Test 6: owners drop req before their burst is used up
    rem = '{0, 2, 3, 0};
    genRun();

    sclr = 1'b1; req = '0; rd = 1'b0; fflush = 1'b1;
    @(negedge clock);
    @(negedge clock);
    sclr = 1'b0; fflush = 1'b0;
    #1;
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_wrreq", wrreq, 0);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_ack", ack, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_ack", i), ack, vecs[i].expAck);
      checkOutput($sformatf("v%0d_grant", i), grant, vecs[i].expGrant);
      checkOutput($sformatf("v%0d_wrreq", i), wrreq, vecs[i].expWrreq);
      writeCheck();
      pushExpected(vecs[i].expAck);
    end

    // Test 3: fill an empty FIFO with no reads; exactly 16 words get in
    @(negedge clock);
    sclr = 1'b1; req = '0; rd = 1'b0; fflush = 1'b1;
    @(negedge clock);
    sclr = 1'b0; fflush = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      expq.push_back(wordOf(0, expSeq[0]));
      expSeq[0]++;
    end
    nAck = 0; nWr = 0; viol = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      req = 4'b0001;
      #1;
      if (ack != 0) nAck++;
      if (((fifoCount + (wrreq ? 1 : 0)) >= DEPTH || fifo_full) && ack != 0) viol++;
      if (wrreq) nWr++;
      writeCheck();
    end
    checkOutput("fill_acks", nAck, DEPTH);
    checkOutput("fill_writes", nWr, DEPTH);
    checkOutput("fill_ack_when_full", viol, 0);
    checkOutput("fill_full", fifo_full, 1);
    checkOutput("fill_grant_held", grant, 4'b0001);
    checkOutput("fill_ack_stall", ack, 0);

    // Test 4: sclr lands on the cycle of the third word
    @(negedge clock);
    sclr = 1'b1; req = '0; fflush = 1'b1;
    @(negedge clock);
    sclr = 1'b0; fflush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      expq.push_back(wordOf(0, expSeq[0]));
      expSeq[0]++;
    end
    kc = 3 + 2 / EB;
    for (int c = 0; c < kc; c++) begin
      @(negedge clock);
      req = 4'b0001;
      #1;
      writeCheck();
    end
    @(negedge clock);
    sclr = 1'b1;
    #1;
    checkOutput("sclr_ack", ack, 0);
    writeCheck();
    @(negedge clock);
    sclr = 1'b0; req = 4'b0011;
    #1;
    checkOutput("after_sclr_grant", grant, 0);
    checkOutput("after_sclr_wrreq", wrreq, 0);
    writeCheck();
    @(negedge clock);
    #1;
    checkOutput("after_sclr_ptr_grant", grant, 4'b0001);
    checkOutput("after_sclr_ack", ack, 4'b0001);
    writeCheck();
    pushExpected(4'b0001);
    @(negedge clock);
    req = '0; sclr = 1'b1;
    #1;
    writeCheck();
    @(negedge clock);
    sclr = 1'b0;
    #1;
    checkOutput("no_partial_write", fifoCount, 3);
    checkOutput("all_words_written", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
